// File: rtl/answer_reader.sv
// Polling master for the answer table: on start, reads addresses 0..N_ADDR-1 and
// streams header, data bytes and an additive checksum out as 8N1 UART frames.
module answer_reader #(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned N_ADDR    = 18,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter logic [4:0]  PARK_ADDR = 5'd31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] addr,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt
);

  localparam int unsigned       DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]        LAST_IDX = 5'(N_ADDR - 1);
  localparam logic [3:0]        LAST_DATA_BIT = 4'd8;
  localparam logic [3:0]        STOP_BIT = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_HDR,
    S_SET_ADDR,
    S_WAIT,
    S_SAMPLE,
    S_TX_DATA,
    S_TX_SUM,
    S_FINISH
  } state_e;

  state_e           state_q,     state_d;
  logic [4:0]       index_q,     index_d;
  logic [7:0]       checksum_q,  checksum_d;
  logic [7:0]       shift_q,     shift_d;
  logic [3:0]       bit_cnt_q,   bit_cnt_d;
  logic [DIV_W-1:0] div_q,       div_d;
  logic [4:0]       addr_q,      addr_d;
  logic             tx_q,        tx_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic in_tx;
  logic bit_end;
  logic byte_end;

  assign in_tx    = (state_q == S_TX_HDR) || (state_q == S_TX_DATA) || (state_q == S_TX_SUM);
  assign bit_end  = (div_q == DIV_LAST);
  assign byte_end = bit_end && (bit_cnt_q == STOP_BIT);

  always_comb begin
    // NOTE: every _d starts from its _q (done from 0) so no branch below can infer a latch.
    state_d     = state_q;
    index_d     = index_q;
    checksum_d  = checksum_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    div_d       = div_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;

    // Bit timer shared by all three transmit states; bit 0 is start, 9 is stop.
    if (in_tx) begin
      if (!bit_end) begin
        div_d = div_q + DIV_W'(1);
      end else begin
        div_d = '0;
        if (bit_cnt_q != STOP_BIT) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_DATA_BIT) begin
            tx_d = 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        addr_d = PARK_ADDR;
        busy_d = 1'b0;
        if (start) begin
          state_d    = S_TX_HDR;
          busy_d     = 1'b1;
          checksum_d = 8'd0;
          index_d    = 5'd0;
          shift_d    = HEADER;
          tx_d       = 1'b0;
          bit_cnt_d  = 4'd0;
          div_d      = '0;
        end
      end

      S_TX_HDR: begin
        if (byte_end) begin
          state_d = S_SET_ADDR;
          tx_d    = 1'b1;
        end
      end

      S_SET_ADDR: begin
        addr_d  = index_q;
        state_d = S_WAIT;
      end

      // The responder registers the new address during this cycle.
      S_WAIT: begin
        state_d = S_SAMPLE;
      end

      S_SAMPLE: begin
        shift_d    = data;
        checksum_d = checksum_q + data;
        tx_d       = 1'b0;
        bit_cnt_d  = 4'd0;
        div_d      = '0;
        state_d    = S_TX_DATA;
      end

      S_TX_DATA: begin
        if (byte_end) begin
          if (index_q == LAST_IDX) begin
            state_d   = S_TX_SUM;
            addr_d    = PARK_ADDR;
            shift_d   = checksum_q;
            tx_d      = 1'b0;
            bit_cnt_d = 4'd0;
            div_d     = '0;
          end else begin
            index_d = index_q + 5'd1;
            tx_d    = 1'b1;
            state_d = S_SET_ADDR;
          end
        end
      end

      S_TX_SUM: begin
        if (byte_end) begin
          state_d = S_FINISH;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end

      S_FINISH: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        addr_d  = PARK_ADDR;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      index_q     <= 5'd0;
      checksum_q  <= 8'd0;
      shift_q     <= 8'd0;
      bit_cnt_q   <= 4'd0;
      div_q       <= '0;
      addr_q      <= PARK_ADDR;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
      state_q     <= state_d;
      index_q     <= index_d;
      checksum_q  <= checksum_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign addr      = addr_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_answer_reader.sv
// Bench for answer_reader: responder model, UART decoder and a queue of
// expected frame bytes checked against the decoded stream.
module tb_answer_reader;

  localparam int         CLK_DIV      = 4;
  localparam int         N_ADDR       = 18;
  localparam logic [7:0] HEADER       = 8'hA5;
  localparam logic [4:0] PARK         = 5'd31;
  localparam logic [7:0] OUTDATA      = 8'h00;
  localparam int         FRAME_BYTES  = N_ADDR + 2;
  localparam int         FRAME_CYCLES = FRAME_BYTES * 10 * CLK_DIV + 3 * N_ADDR + 1;
  localparam int         TIMEOUT      = 3 * FRAME_CYCLES;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic [4:0] addr;
  logic [7:0] data  = 8'hEE;
  logic       tx;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  answer_reader #(
    .CLK_DIV  (CLK_DIV),
    .N_ADDR   (N_ADDR),
    .HEADER   (HEADER),
    .PARK_ADDR(PARK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .addr     (addr),
    .data     (data),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Answer table contents: addr 0 returns the read counter, 1..15 return 10*addr.
  function automatic logic [7:0] table_val(input logic [4:0] a, input logic [7:0] cnt0);
    if (a == 5'd0) return cnt0;
    if (a <= 5'd15) return 8'(10 * int'(a));
    return OUTDATA;
  endfunction

  // Responder: data valid only in the cycle after an address change, junk otherwise.
  logic [4:0] last_addr = PARK;
  logic [7:0] resp_cnt  = 8'd0;
  int         visits    = 0;
  int         order_err = 0;

  always @(posedge clk) begin
    last_addr <= addr;
    if (rst && (addr !== last_addr)) begin
      data <= table_val(addr, resp_cnt);
      if (addr == 5'(N_ADDR - 1)) resp_cnt <= resp_cnt + 8'd1;
      if (addr != PARK) begin
        visits <= visits + 1;
        if (addr != ((last_addr == PARK) ? 5'd0 : last_addr + 5'd1)) order_err <= order_err + 1;
      end
    end else begin
      data <= 8'hEE;
    end
  end

  int done_cnt = 0;
  int busy_cyc = 0;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  // UART decoder: 40 samples per byte; bit 8 of each entry flags a timing error.
  function automatic logic [8:0] decode(input logic [39:0] s);
    logic       err;
    logic [7:0] b;
    err = 1'b0;
    b   = 8'd0;
    for (int bi = 0; bi < 10; bi++)
      for (int p = 0; p < 4; p++)
        if (s[4*bi+p] !== s[4*bi+2]) err = 1'b1;
    if (s[2] !== 1'b0 || s[38] !== 1'b1) err = 1'b1;
    for (int i = 0; i < 8; i++) b[i] = s[4*(i+1)+2];
    return {err, b};
  endfunction

  logic [8:0]  rx_q[$];
  logic [39:0] mon_s = 40'd0;
  int          mon_k = 0;
  logic        mon_on = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_on <= 1'b0;
      mon_k  <= 0;
    end else if (!mon_on) begin
      if (tx === 1'b0) begin
        mon_on <= 1'b1;
        mon_k  <= 1;
        mon_s  <= 40'd0;
      end
    end else begin
      mon_s[mon_k] <= tx;
      if (mon_k == 39) begin
        mon_on <= 1'b0;
        rx_q.push_back(decode({tx, mon_s[38:0]}));
      end else begin
        mon_k <= mon_k + 1;
      end
    end
  end

  logic [7:0] exp_q[$];
  int rx_rd     = 0;
  int exp_rd    = 0;
  int base_busy = 0;
  int base_done = 0;
  int base_vis  = 0;

  task automatic push_frame(input logic [7:0] cnt0);
    logic [7:0] sum;
    logic [7:0] v;
    sum = 8'd0;
    exp_q.push_back(HEADER);
    for (int a = 0; a < N_ADDR; a++) begin
      v   = table_val(5'(a), cnt0);
      sum = sum + v;
      exp_q.push_back(v);
    end
    exp_q.push_back(sum);
  endtask

  // Called at a negedge; start is seen by the DUT on the following posedge.
  task automatic start_frame(input string tag, input logic [7:0] cnt0);
    push_frame(cnt0);
    base_busy = busy_cyc;
    base_done = done_cnt;
    base_vis  = visits;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_hdr_start_bit"}, tx, 0);
  endtask

  task automatic wait_bytes(input string tag, input int target);
    int n;
    n = 0;
    while (rx_q.size() < target && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, 32'(rx_q.size() >= target), 1);
  endtask

  task automatic compare_frame(input string tag);
    int         wbad;
    logic [8:0] got;
    wbad = 0;
    check({tag, "_nbytes"}, rx_q.size() - rx_rd, FRAME_BYTES);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      got = (rx_rd < rx_q.size()) ? rx_q[rx_rd] : 9'h1FF;
      if (got[8]) wbad++;
      check($sformatf("%s_byte%0d", tag, i), got[7:0], exp_q[exp_rd]);
      rx_rd++;
      exp_rd++;
    end
    check({tag, "_bit_width"}, wbad, 0);
    rx_rd = rx_q.size();
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] fc, input bit poke_finish);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < TIMEOUT) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    check({tag, "_done_seen"}, seen, 1);
    if (poke_finish) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_frame_cnt"}, frame_cnt, fc);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_addr_parked"}, addr, PARK);
    check({tag, "_tx_idle"}, tx, 1);
    check({tag, "_frame_len"}, busy_cyc - base_busy, FRAME_CYCLES);
    check({tag, "_done_pulses"}, done_cnt - base_done, 1);
    check({tag, "_addr_visits"}, visits - base_vis, N_ADDR);
    check({tag, "_addr_order"}, order_err, 0);
    compare_frame(tag);
  endtask

  initial begin
    int quiet_bad;
    int held_done;
    int held_bytes;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_addr", addr, PARK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    quiet_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || addr !== PARK || busy !== 1'b0 || done !== 1'b0 || frame_cnt !== 8'd0)
        quiet_bad++;
    end
    check("idle_stable", quiet_bad, 0);
    check("idle_no_bytes", rx_q.size(), 0);

    // Frames 1 and 2; frame 2 starts in the first IDLE cycle after done.
    start_frame("f1", 8'd0);
    finish_frame("f1", 8'd1, 1'b0);
    start_frame("f2", 8'd1);
    finish_frame("f2", 8'd2, 1'b0);

    // Frame 3: start pulsed mid-frame and again in the FINISH cycle.
    start_frame("f3", 8'd2);
    wait_bytes("f3_byte5", rx_rd + 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_frame("f3", 8'd3, 1'b1);
    held_done  = done_cnt;
    held_bytes = rx_q.size();
    quiet_bad  = 0;
    repeat (FRAME_CYCLES + 20) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) quiet_bad++;
    end
    check("f3_no_second_frame", quiet_bad, 0);
    check("f3_no_extra_done", done_cnt - held_done, 0);
    check("f3_no_extra_bytes", rx_q.size() - held_bytes, 0);
    check("f3_frame_cnt_hold", frame_cnt, 3);

    // Frame 4 aborted by reset during byte 10.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    held_done = done_cnt;
    wait_bytes("abort_byte10", rx_rd + 10);
    repeat (15) @(negedge clk);
    check("abort_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_addr", addr, PARK);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_frame_cnt", frame_cnt, 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - held_done, 0);
    rst = 1'b1;
    quiet_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1 || addr !== PARK) quiet_bad++;
    end
    check("abort_waits_for_start", quiet_bad, 0);
    rx_rd = rx_q.size();

    // Address 17 was never reached in the aborted frame, so the counter is still 3.
    start_frame("f5", 8'd3);
    finish_frame("f5", 8'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
